// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with parallel load,
// shift right/left, optional rotate, serial in/out on both ends and a frame
// counter that pulses frame_done after every WIDTH shift operations.
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN enables modes 100/101
// (rotate right/left); without it those modes decode as hold.
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101
  } mode_e;

  logic [WIDTH-1:0] next_q;
  logic [CW-1:0]    next_cnt;
  logic             next_fd;
  logic             counted;
  logic             load;
  logic             last_shift;

  // The serial outputs are the end bits of the register, no extra delay.
  assign sout_r     = q[0];
  assign sout_l     = q[WIDTH-1];
  assign last_shift = (cnt == CW'(WIDTH - 1));

  // Decode the operation into the next register value and whether it counts.
  always_comb begin
    next_q  = q;
    counted = 1'b0;
    load    = 1'b0;
    case (mode)
      MODE_SHR: begin
        next_q  = {sin_r, q[WIDTH-1:1]};
        counted = 1'b1;
      end
      MODE_SHL: begin
        next_q  = {q[WIDTH-2:0], sin_l};
        counted = 1'b1;
      end
      MODE_LOAD: begin
        next_q = d;
        load   = 1'b1;
      end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      MODE_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        counted = 1'b1;
      end
      MODE_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        counted = 1'b1;
      end
`endif
      default: begin
        next_q  = q;
        counted = 1'b0;
      end
    endcase
  end

  // Frame counter: a load restarts the frame, the WIDTH-th counted op wraps
  // the count to zero and raises frame_done for the following cycle.
  always_comb begin
    next_cnt = cnt;
    next_fd  = 1'b0;
    if (load) begin
      next_cnt = '0;
    end else if (counted) begin
      if (last_shift) begin
        next_cnt = '0;
        next_fd  = 1'b1;
      end else begin
        next_cnt = cnt + CW'(1);
      end
    end
  end

  // State register: reset wins over enable, disabled cycles freeze q and cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      frame_done <= 1'b0;
    end else begin
      q          <= next_q;
      cnt        <= next_cnt;
      frame_done <= next_fd;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg at WIDTH=8.
// Expected values are computed from a behavioural model when stimulus is
// driven, queued, and popped after each clock edge for comparison.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             frame_done;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             fd;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    m_cnt;
  logic             m_fd;
  int               n_checks;
  int               n_fail;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .d          (d),
    .q          (q),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, predict the result, queue it, and step past
  // the edge so outputs are sampled away from it.
  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic sr, input logic sl, input logic [WIDTH-1:0] dd);
    logic counted;
    reset   = r;
    en      = e;
    mode    = m;
    sin_r   = sr;
    sin_l   = sl;
    d       = dd;
    counted = 1'b0;
    if (r) begin
      m_q = '0; m_cnt = '0; m_fd = 1'b0;
    end else if (!e) begin
      m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      case (m)
        3'b001: begin m_q = {sr, m_q[WIDTH-1:1]}; counted = 1'b1; end
        3'b010: begin m_q = {m_q[WIDTH-2:0], sl}; counted = 1'b1; end
        3'b011: begin m_q = dd; m_cnt = '0; end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        3'b100: begin m_q = {m_q[0], m_q[WIDTH-1:1]}; counted = 1'b1; end
        3'b101: begin m_q = {m_q[WIDTH-2:0], m_q[WIDTH-1]}; counted = 1'b1; end
`endif
        default: ;
      endcase
      if (counted) begin
        if (m_cnt == CW'(WIDTH - 1)) begin
          m_cnt = '0; m_fd = 1'b1;
        end else begin
          m_cnt = m_cnt + CW'(1);
        end
      end
    end
    sb.push_back('{q: m_q, cnt: m_cnt, fd: m_fd});
    @(posedge clk);
    #1;
  endtask

  // Reset wins over a simultaneous enabled load of all ones.
  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'hFF);
    e = sb.pop_front();
    n_checks++;
    if ({sout_l, sout_r, frame_done, cnt, q} !== {e.q[WIDTH-1], e.q[0], e.fd, e.cnt, e.q}) begin
      n_fail++;
      $display("[TB] FAIL reset_sb: got q=%h cnt=%0d fd=%b, want q=%h cnt=%0d fd=%b", q, cnt, frame_done, e.q, e.cnt, e.fd);
    end
    n_checks++;
    if ({q, cnt, frame_done} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_const: got q=%h cnt=%0d fd=%b, want q=00 cnt=0 fd=0", q, cnt, frame_done);
    end
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00);
    void'(sb.pop_front());
  endtask

  // Load, serial-out checks, one right shift, then three disabled cycles.
  task automatic test_shift_right();
    exp_t e;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'hA5);
    e = sb.pop_front();
    n_checks++;
    if ({sout_l, sout_r, q, cnt} !== {1'b1, 1'b1, 8'hA5, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL load_a5: got q=%h sout_l=%b sout_r=%b cnt=%0d, want q=a5 1 1 cnt=0", q, sout_l, sout_r, cnt);
    end
    drive(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
    e = sb.pop_front();
    n_checks++;
    if ({q, cnt, frame_done} !== {8'hD2, 3'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL shr_d2: got q=%h cnt=%0d fd=%b, want q=d2 cnt=1 fd=0", q, cnt, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 8'hFF);
      e = sb.pop_front();
      n_checks++;
      if ({sout_l, sout_r, frame_done, cnt, q} !== {e.q[WIDTH-1], e.q[0], e.fd, e.cnt, e.q} || q !== 8'hD2 || cnt !== 3'd1) begin
        n_fail++;
        $display("[TB] FAIL en_hold[%0d]: got q=%h cnt=%0d, want q=d2 cnt=1", i, q, cnt);
      end
    end
  endtask

  // Left shift brings sin_l into the LSB.
  task automatic test_shift_left();
    exp_t e;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'hA5);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 8'hFF);
    e = sb.pop_front();
    n_checks++;
    if ({q, cnt, frame_done, sout_l, sout_r} !== {8'h4A, 3'd1, 1'b0, 1'b0, 1'b0} || q !== e.q) begin
      n_fail++;
      $display("[TB] FAIL shl_4a: got q=%h cnt=%0d fd=%b, want q=4a cnt=1 fd=0", q, cnt, frame_done);
    end
  endtask

  // Eight right shifts of ones after loading zero, optionally with two idle
  // cycles after shift four; frame_done must pulse only after shift eight.
  task automatic test_frame(input bit with_gap);
    exp_t e;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h00);
    void'(sb.pop_front());
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 8'h00);
      e = sb.pop_front();
      n_checks++;
      if ({frame_done, cnt, q} !== {e.fd, e.cnt, e.q} || cnt !== CW'(i % 8) || frame_done !== (i == 8)) begin
        n_fail++;
        $display("[TB] FAIL frame gap=%0d shift %0d: got q=%h cnt=%0d fd=%b, want q=%h cnt=%0d fd=%b", with_gap, i, q, cnt, frame_done, e.q, i % 8, i == 8);
      end
      if (with_gap && i == 4) begin
        drive(1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 8'hFF);
        void'(sb.pop_front());
        drive(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 8'hFF);
        e = sb.pop_front();
        n_checks++;
        if ({cnt, frame_done} !== {3'd4, 1'b0}) begin
          n_fail++;
          $display("[TB] FAIL frame_pause: got cnt=%0d fd=%b, want cnt=4 fd=0", cnt, frame_done);
        end
      end
    end
    n_checks++;
    if (q !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL frame_q: got q=%h, want q=ff", q);
    end
    drive(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00);
    e = sb.pop_front();
    n_checks++;
    if (frame_done !== 1'b0 || cnt !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL frame_pulse_len: got fd=%b cnt=%0d, want fd=0 cnt=0", frame_done, cnt);
    end
  endtask

  // Rotate right of 0x81; decodes as hold when the rotate feature is absent.
  task automatic test_rotate();
    exp_t e;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h81);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 8'hFF);
    e = sb.pop_front();
    n_checks++;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    if ({q, cnt} !== {8'hC0, 3'd1} || q !== e.q) begin
      n_fail++;
      $display("[TB] FAIL ror_81: got q=%h cnt=%0d, want q=c0 cnt=1", q, cnt);
    end
`else
    if ({q, cnt} !== {8'h81, 3'd0} || q !== e.q) begin
      n_fail++;
      $display("[TB] FAIL ror_81_off: got q=%h cnt=%0d, want q=81 cnt=0", q, cnt);
    end
`endif
    drive(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 8'hFF);
    e = sb.pop_front();
    n_checks++;
    if ({frame_done, cnt, q} !== {e.fd, e.cnt, e.q}) begin
      n_fail++;
      $display("[TB] FAIL rol: got q=%h cnt=%0d, want q=%h cnt=%0d", q, cnt, e.q, e.cnt);
    end
  endtask

  // Reset after five shifts discards the partial frame; a new frame works.
  task automatic test_reset_mid_frame();
    exp_t e;
    bit   saw_pulse;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h3C);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
      void'(sb.pop_front());
    end
    n_checks++;
    if (cnt !== 3'd5) begin
      n_fail++;
      $display("[TB] FAIL mid_cnt5: got cnt=%0d, want cnt=5", cnt);
    end
    drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 8'h00);
    e = sb.pop_front();
    n_checks++;
    if ({q, cnt, frame_done} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got q=%h cnt=%0d fd=%b, want q=00 cnt=0 fd=0", q, cnt, frame_done);
    end
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h5A);
    void'(sb.pop_front());
    saw_pulse = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 8'h00);
      e = sb.pop_front();
      if (frame_done) saw_pulse = (i == 8);
      n_checks++;
      if ({frame_done, cnt, q} !== {e.fd, e.cnt, e.q}) begin
        n_fail++;
        $display("[TB] FAIL mid_refill %0d: got q=%h cnt=%0d fd=%b, want q=%h cnt=%0d fd=%b", i, q, cnt, frame_done, e.q, e.cnt, e.fd);
      end
    end
    n_checks++;
    if (!saw_pulse) begin
      n_fail++;
      $display("[TB] FAIL mid_refill_pulse: got no pulse at shift 8, want one");
    end
  endtask

  // Back-to-back frames and random mixed traffic against the model.
  task automatic test_back_to_back();
    exp_t e;
    drive(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 8'hC3);
    void'(sb.pop_front());
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, 3'b010, 1'b0, 1'($urandom_range(1)), 8'h00);
      e = sb.pop_front();
      n_checks++;
      if ({frame_done, cnt, q} !== {e.fd, e.cnt, e.q} || frame_done !== (i == 8 || i == 16)) begin
        n_fail++;
        $display("[TB] FAIL b2b %0d: got q=%h cnt=%0d fd=%b, want q=%h cnt=%0d fd=%b", i, q, cnt, frame_done, e.q, e.cnt, e.fd);
      end
    end
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(19) == 0), 1'($urandom_range(5) != 0), 3'($urandom_range(7)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)));
      e = sb.pop_front();
      n_checks++;
      if ({sout_l, sout_r, frame_done, cnt, q} !== {e.q[WIDTH-1], e.q[0], e.fd, e.cnt, e.q}) begin
        n_fail++;
        $display("[TB] FAIL random %0d: got q=%h cnt=%0d fd=%b, want q=%h cnt=%0d fd=%b", i, q, cnt, frame_done, e.q, e.cnt, e.fd);
      end
    end
  endtask

  // Test sequence.
  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    en       = 1'b0;
    mode     = 3'b000;
    sin_r    = 1'b0;
    sin_l    = 1'b0;
    d        = '0;
    m_q      = '0;
    m_cnt    = '0;
    m_fd     = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    $display("[TB] starting univ_shift_reg tests");
    test_reset();
    test_shift_right();
    test_shift_left();
    test_frame(1'b0);
    test_frame(1'b1);
    test_rotate();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: synchronous parallel load, shift right, shift left and (optionally) rotate, with serial in/out on both ends. Adds a frame counter that pulses `frame_done` after every WIDTH shift operations, so the block can act as a serialiser or deserialiser. It is the general-purpose successor to the fixed 4-bit serial-in shift register in the sequential-logic library.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- CW (localparam), $clog2(WIDTH), frame counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  operation enable; 0 = hold everything.
- mode  in  3  operation select:
  - 000 = hold
  - 001 = shift right
  - 010 = shift left
  - 011 = parallel load
  - 100 = rotate right
  - 101 = rotate left
  - 110/111 = hold
- sin_r  in  1  serial input; enters the MSB on shift right.
- sin_l  in  1  serial input; enters the LSB on shift left.
- d  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- sout_r  out  1  equals q[0]; the bit leaving on shift right.
- sout_l  out  1  equals q[WIDTH-1]; the bit leaving on shift left.
- cnt  out  CW  number of shifts or rotates since the last load, reset or frame wrap.
- frame_done  out  1  one-cycle pulse marking completion of the WIDTH-th shift.

## Operation
- Priority: reset > en=0 > mode.
- Reset sets q=0, cnt=0 and frame_done=0. It is evaluated only at the clock edge.
- en=0 holds q and cnt, and sets frame_done <= 0.
- Hold (000, 110, 111): q and cnt unchanged; frame_done <= 0.
- Shift right: q <= {sin_r, q[WIDTH-1:1]}.
- Shift left: q <= {q[WIDTH-2:0], sin_l}.
- Rotate right: q <= {q[0], q[WIDTH-1:1]}.
- Rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- Counted op (any shift or rotate):
  - If cnt == WIDTH-1: cnt <= 0 and frame_done <= 1.
  - Otherwise: cnt <= cnt+1 and frame_done <= 0.
- Parallel load: q <= d, cnt <= 0, frame_done <= 0. A load restarts the frame.
- Serial inputs are ignored in every mode except the matching shift direction. Parallel input `d` is ignored except on load.
- sout_r and sout_l are wired directly from q bits. They carry no extra logic or latency.

## Timing
- Single-cycle latency: an operation sampled at edge N is visible on q, cnt and frame_done right after edge N.
- frame_done is registered. It is high for exactly the one cycle following the edge that performed the WIDTH-th counted op. It never stays high for two consecutive cycles unless two consecutive edges each complete a frame; this is impossible for WIDTH >= 2.
- Paused frames: en=0 or hold cycles between shifts pause the frame count; they do not reset it.
- Wrap-around: back-to-back frames are supported. The shift after a wrap counts as shift 1 of the next frame, with no dead cycle.
- Reset mid-frame: the partial count is discarded and no frame_done is produced.
- Reset and load in the same cycle: reset wins.

## Configuration
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- Defined: modes 100 and 101 rotate as described and are counted ops.
- Undefined: modes 100 and 101 decode as hold. q and cnt are unchanged, frame_done <= 0, and no rotate logic is synthesised.

## Test plan
All scenarios use WIDTH=8.
1. Reset priority: assert reset with en=1, mode=011, d=0xFF. After the edge, q=0x00, cnt=0, frame_done=0.
2. Shift right: load 0xA5, then check sout_r=1 and sout_l=1. Shift right with sin_r=1: q=0xD2, cnt=1. Then disable with en=0 for 3 cycles: q stays 0xD2 and cnt stays 1.
3. Shift left: load 0xA5, shift left with sin_l=0: q=0x4A.
4. Frame counting:
   - Load 0x00, then 8 consecutive shift-right edges with sin_r=1. cnt steps 1..7 then 0, q=0xFF, and frame_done is high only in the cycle after the 8th edge.
   - Repeat with 2 idle cycles inserted after shift 4. frame_done still pulses after the 8th shift.
5. Rotate right with the macro: load 0x81, rotate right: q=0xC0, cnt=1. Without the macro: q stays 0x81 and cnt stays 0.
6. Reset mid-frame: load, do 5 shifts (cnt=5), then assert reset. cnt=0, q=0, and no frame_done pulse. Then load and do 8 shifts; frame_done pulses normally.
